// File: rtl/pc_seq.sv
// pc_seq: fetch program-counter sequencer (boot, increment, redirect, irq, halt).
// Optional stall-cycle counter enabled by defining PC_SEQ_PERF_EN.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module pc_seq #(
  parameter logic [`SIZE_ADDR-1:0] RESET_VEC = '0,
  parameter logic [`SIZE_ADDR-1:0] IRQ_VEC   = `SIZE_ADDR'd16,
  parameter logic [`SIZE_ADDR-1:0] PC_INC    = `SIZE_ADDR'd1
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic                  iw_mem_ready,
  input  logic                  iw_stall,
  input  logic                  iw_branch_valid,
  input  logic [`SIZE_ADDR-1:0] iw_branch_pc,
  input  logic                  iw_irq_req,
  input  logic                  iw_halt,
`ifdef PC_SEQ_PERF_EN
  output logic [31:0]           ow_stall_cnt,
`endif
  output logic [`SIZE_ADDR-1:0] ow_pc,
  output logic                  ow_pc_valid,
  output logic                  ow_flush,
  output logic                  ow_irq_ack,
  output logic [`SIZE_ADDR-1:0] ow_epc,
  output logic                  ow_halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [`SIZE_ADDR-1:0] pc_q, pc_d;
  logic [`SIZE_ADDR-1:0] epc_q, epc_d;
  logic                  valid_q, valid_d;
  logic                  flush_q, flush_d;
  logic                  ack_q, ack_d;
  logic                  halted_q, halted_d;

  logic accept;
  logic irq_ok;

  // Qualified events; irq is masked for the cycle its ack is showing.
  always_comb begin
    accept = valid_q & iw_mem_ready & ~iw_stall;
    irq_ok = iw_irq_req & ~ack_q;
  end

  // Next-state and registered-output decode, priority branch > irq > halt > accept.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    valid_d  = valid_q;
    flush_d  = 1'b0;
    ack_d    = 1'b0;
    halted_d = halted_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
        pc_d    = RESET_VEC;
      end
      RUN: begin
        if (iw_branch_valid) begin
          pc_d    = iw_branch_pc;
          flush_d = 1'b1;
        end else if (irq_ok) begin
          epc_d   = pc_q;
          pc_d    = IRQ_VEC;
          ack_d   = 1'b1;
          flush_d = 1'b1;
        end else if (iw_halt) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (accept) begin
          pc_d = pc_q + PC_INC;
        end
      end
      HALT: begin
        if (irq_ok) begin
          epc_d    = pc_q;
          pc_d     = IRQ_VEC;
          ack_d    = 1'b1;
          flush_d  = 1'b1;
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end else if (!iw_halt) begin
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      ack_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      ack_q    <= ack_d;
      halted_q <= halted_d;
    end
  end

  assign ow_pc       = pc_q;
  assign ow_pc_valid = valid_q;
  assign ow_flush    = flush_q;
  assign ow_irq_ack  = ack_q;
  assign ow_epc      = epc_q;
  assign ow_halted   = halted_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] cnt_q, cnt_d;
  logic        stalled;

  // Count live RUN cycles that neither advance nor redirect, saturating.
  always_comb begin
    stalled = (state_q == RUN) & valid_q & ~accept
            & ~iw_branch_valid & ~irq_ok;
    cnt_d   = cnt_q;
    if (stalled && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign ow_stall_cnt = cnt_q;
`endif

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Program-counter sequencer that drives the instruction-address stage's `iw_pc` input. It owns fetch sequencing: boot vector, sequential increment, branch redirect, interrupt entry, halt/wake and stall hold.
- It sits directly ahead of the IA stage. It is the only writer of the fetch address.
- Its flush output kills in-flight fetch stages on any redirect.

Parameters:
- RESET_VEC, 0, fetch address issued after reset.
- IRQ_VEC, 16, fetch address on interrupt entry.
- PC_INC, 1, sequential increment per accepted fetch.

Ports:
- iw_clk  in  1  clock.
- iw_rst_n  in  1  reset, asynchronous assert, active-low.
- iw_mem_ready  in  1  memory accepts the fetch on ow_pc this cycle.
- iw_stall  in  1  downstream backpressure; hold PC.
- iw_branch_valid  in  1  redirect request, one cycle.
- iw_branch_pc  in  `SIZE_ADDR  redirect target.
- iw_irq_req  in  1  interrupt request, level.
- iw_halt  in  1  halt request, level.
- ow_pc  out  `SIZE_ADDR  fetch address to IA stage.
- ow_pc_valid  out  1  ow_pc is a live fetch.
- ow_flush  out  1  one-cycle pulse: discard in-flight fetches.
- ow_irq_ack  out  1  one-cycle pulse on interrupt entry.
- ow_epc  out  `SIZE_ADDR  return address captured at interrupt entry.
- ow_halted  out  1  sequencer in HALT.

Behaviour:
- All outputs are registered. No combinational input-to-output path.
- Reset (iw_rst_n=0, asynchronous):
  - state=BOOT, ow_pc=RESET_VEC, ow_epc=0.
  - ow_pc_valid=0, ow_flush=0, ow_irq_ack=0, ow_halted=0.
- State BOOT: one cycle, then RUN with ow_pc_valid=1 and ow_pc=RESET_VEC. Inputs are ignored in BOOT.
- Define "accept" = ow_pc_valid & iw_mem_ready & !iw_stall.
- State RUN, evaluated each edge, highest priority first:
  1. iw_branch_valid: ow_pc<=iw_branch_pc; ow_flush<=1. Overrides stall and not-ready.
  2. iw_irq_req: ow_epc<=ow_pc (the unissued or current address); ow_pc<=IRQ_VEC; ow_irq_ack<=1; ow_flush<=1.
  3. iw_halt: go to HALT; ow_pc_valid<=0; ow_halted<=1; ow_pc holds.
  4. accept: ow_pc<=ow_pc+PC_INC.
  5. otherwise: hold ow_pc.
- Interrupt masking: ow_irq_ack pulses once per entry. A new entry is blocked in the cycle after ow_irq_ack, so a held level request does not retrigger immediately. It re-enters only on the next edge where req is still high.
- State HALT:
  - iw_branch_valid is ignored.
  - iw_irq_req: perform interrupt entry as in RUN with ow_epc=held ow_pc, return to RUN, ow_pc_valid<=1, ow_halted<=0.
  - Else !iw_halt: return to RUN; resume at the held ow_pc, no flush.
- Pulses: ow_flush and ow_irq_ack are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Arithmetic: ow_pc+PC_INC is modulo 2^`SIZE_ADDR. From the all-ones address it wraps to PC_INC-1, with no flag.
- Reset mid-operation: immediate return to reset values. Any pending branch or irq is lost.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined:
  - Adds output ow_stall_cnt, 32 bits.
  - Counts cycles in RUN with ow_pc_valid=1 and no accept and no redirect.
  - Saturates at 0xFFFFFFFF. Cleared by reset only.
- When undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, mem_ready=1, no stall, PC_INC=1 -> cycle 1 BOOT valid=0; then ow_pc 0,1,2,3 on successive cycles, valid=1.
- In RUN at pc=5, stall=1 for 3 cycles, then 0 -> ow_pc holds 5 for 3 cycles, then 6. With PC_SEQ_PERF_EN, ow_stall_cnt=3.
- Branch and irq in the same cycle, stall=1, branch_pc=0x40 -> next ow_pc=0x40, one flush pulse, no irq_ack. Irq is taken the following cycle: ow_epc=0x40, ow_pc=IRQ_VEC.
- halt=1 at pc=9 -> ow_halted=1, valid=0, pc=9. Then irq_req=1 -> irq_ack pulse, ow_epc=9, ow_pc=16, valid=1, halted=0.
- ow_pc=all-ones, accept -> ow_pc=0. Then assert iw_rst_n=0 mid-stream -> all outputs return to reset values in the same cycle (async), and BOOT follows release.
